// File: rtl/orb_pkg.sv
// orb_pkg: shared helpers and defaults for the frame pipe.
//   clog2_min1   : ceil(log2(v)), never below 1, so counter/pointer vectors
//                  always have at least one bit.
//   DEF_FRAME_W  : default pixels per line.
//   DEF_FRAME_H  : default lines per frame.
//   DEF_HS_W     : pixel-counter width for the default line length.
//   DEF_VS_W     : line-counter width for the default frame height.
package orb_pkg;

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < v) begin
                r = r + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int DEF_FRAME_W = 720;
    localparam int DEF_FRAME_H = 480;
    localparam int DEF_HS_W    = clog2_min1(DEF_FRAME_W);
    localparam int DEF_VS_W    = clog2_min1(DEF_FRAME_H);

endpackage

// File: rtl/axis_sync_fifo.sv
// axis_sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, rst : clock and synchronous active-high reset (pointers, count)
//   wr_en    : write wr_data (ignored while full)
//   rd_en    : pop the head (ignored while empty)
//   rd_data  : current head entry, valid whenever empty is 0
//   full, empty, count : occupancy status
module axis_sync_fifo
    import orb_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [clog2_min1(DEPTH):0] count
);

    localparam int AW    = clog2_min1(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_wr, do_rd;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;
    assign rd_data = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so the pointers wrap on natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_wr) - CNT_W'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is visible until count says so.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_frame_pipe.sv
// axis_frame_pipe: wraps a fixed-latency pixel core with AXI-Stream in/out.
//   axi_Mclk, axi_reset        : clock, synchronous active-high reset
//   s_axis_*                   : input pixels (tdata/tvalid/tlast/tready)
//   core_en/core_pix           : beat handed to the core
//   core_hs_cnt/core_vs_cnt    : (x, y) of core_pix within the frame
//   core_res                   : core output, PIPE_LAT cycles after core_en
//   m_axis_*                   : output stream (tdata/tvalid/tlast/tkeep/tready)
//   frame_done                 : pulse when the last beat of a frame leaves
//   tlast_err                  : sticky, input tlast disagreed with position
// Handshake: a beat transfers on a rising edge where valid and ready are both
// 1; valid never waits on ready, and data/last are held while valid && !ready.
module axis_frame_pipe
    import orb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter int FRAME_H    = DEF_FRAME_H,
    parameter int PIPE_LAT   = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                           axi_Mclk,
    input  logic                           axi_reset,
    input  logic [DATA_W-1:0]              s_axis_tdata,
    input  logic                           s_axis_tvalid,
    input  logic                           s_axis_tlast,
    output logic                           s_axis_tready,
    output logic                           core_en,
    output logic [DATA_W-1:0]              core_pix,
    output logic [clog2_min1(FRAME_W)-1:0] core_hs_cnt,
    output logic [clog2_min1(FRAME_H)-1:0] core_vs_cnt,
    input  logic [DATA_W-1:0]              core_res,
    output logic [DATA_W-1:0]              m_axis_tdata,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    output logic [DATA_W/8-1:0]            m_axis_tkeep,
    input  logic                           m_axis_tready,
    output logic                           frame_done,
    output logic                           tlast_err
);

    localparam int HS_W  = clog2_min1(FRAME_W);
    localparam int VS_W  = clog2_min1(FRAME_H);
    localparam int CNT_W = clog2_min1(FIFO_DEPTH) + 1;

    logic [HS_W-1:0]     hs_q, hs_d;
    logic [VS_W-1:0]     vs_q, vs_d;
    logic [CNT_W-1:0]    used_q, used_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic [PIPE_LAT-1:0] dl_vld_q, dl_vld_d;
    logic [PIPE_LAT-1:0] dl_last_q, dl_last_d;

    logic                accept, pop, comp_last;
    logic                fifo_wr, fifo_full, fifo_empty;
    logic [DATA_W:0]     fifo_wdata, fifo_rdata;
    logic [CNT_W-1:0]    fifo_count;

    assign accept    = s_axis_tvalid & s_axis_tready;
    assign pop       = m_axis_tvalid & m_axis_tready;
    assign comp_last = (hs_q == HS_W'(FRAME_W - 1)) && (vs_q == VS_W'(FRAME_H - 1));

    always_comb begin
        hs_d  = hs_q;
        vs_d  = vs_q;
        err_d = err_q;
        if (accept) begin
            if (s_axis_tlast != comp_last) begin
                err_d = 1'b1;
            end
            // Either tlast restarts the frame, so a bad input frame cannot
            // shift the coordinates of every frame that follows it.
            if (s_axis_tlast || comp_last) begin
                hs_d = '0;
                vs_d = '0;
            end else if (hs_q == HS_W'(FRAME_W - 1)) begin
                hs_d = '0;
                vs_d = (vs_q == VS_W'(FRAME_H - 1)) ? '0 : vs_q + 1'b1;
            end else begin
                hs_d = hs_q + 1'b1;
            end
        end
    end

    // used = fifo_count + inflight. A beat moving from the delay line into
    // the FIFO leaves the sum unchanged, so only accept and pop move it.
    // Ready is registered from the next value, so it matches used < DEPTH
    // every cycle and never lets a result arrive at a full FIFO.
    always_comb begin
        used_d  = used_q + CNT_W'(accept) - CNT_W'(pop);
        ready_d = (used_d < CNT_W'(FIFO_DEPTH));
    end

    always_comb begin
        dl_vld_d     = '0;
        dl_last_d    = '0;
        dl_vld_d[0]  = accept;
        dl_last_d[0] = comp_last;
        for (int i = 1; i < PIPE_LAT; i++) begin
            dl_vld_d[i]  = dl_vld_q[i-1];
            dl_last_d[i] = dl_last_q[i-1];
        end
    end

    always_ff @(posedge axi_Mclk) begin
        if (axi_reset) begin
            hs_q      <= '0;
            vs_q      <= '0;
            used_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            dl_vld_q  <= '0;
            dl_last_q <= '0;
        end else begin
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            used_q    <= used_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            dl_vld_q  <= dl_vld_d;
            dl_last_q <= dl_last_d;
        end
    end

    // The delay-line tail lines up with the cycle core_res is valid.
    assign fifo_wr    = dl_vld_q[PIPE_LAT-1];
    assign fifo_wdata = {dl_last_q[PIPE_LAT-1], core_res};

    axis_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (axi_Mclk),
        .rst     (axi_reset),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wdata),
        .rd_en   (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Outputs are forced low during the reset cycle itself, before the
    // synchronous clear has landed.
    assign s_axis_tready = ready_q & ~axi_reset;
    assign core_en       = accept;
    assign core_pix      = s_axis_tdata;
    assign core_hs_cnt   = hs_q;
    assign core_vs_cnt   = vs_q;
    assign m_axis_tvalid = ~fifo_empty & ~axi_reset;
    assign m_axis_tdata  = fifo_rdata[DATA_W-1:0];
    assign m_axis_tlast  = fifo_rdata[DATA_W] & m_axis_tvalid;
    assign m_axis_tkeep  = {(DATA_W/8){m_axis_tvalid}};
    assign frame_done    = pop & m_axis_tlast;
    assign tlast_err     = err_q & ~axi_reset;

    // Credit accounting invariant: no write into a full FIFO, and the FIFO
    // never holds more than the credits handed out.
    assert property (@(posedge axi_Mclk) disable iff (axi_reset)
        !(fifo_wr && fifo_full) && (fifo_count <= used_q));

endmodule

// File: tb/tb_axis_frame_pipe.sv
module tb_axis_frame_pipe;
  import orb_pkg::*;

  localparam int DATA_W     = 32;
  localparam int FRAME_W    = 4;
  localparam int FRAME_H    = 2;
  localparam int PIPE_LAT   = 3;
  localparam int FIFO_DEPTH = 8;

  logic                           axi_Mclk;
  logic                           axi_reset;
  logic [DATA_W-1:0]              s_axis_tdata;
  logic                           s_axis_tvalid;
  logic                           s_axis_tlast;
  logic                           s_axis_tready;
  logic                           core_en;
  logic [DATA_W-1:0]              core_pix;
  logic [clog2_min1(FRAME_W)-1:0] core_hs_cnt;
  logic [clog2_min1(FRAME_H)-1:0] core_vs_cnt;
  logic [DATA_W-1:0]              core_res;
  logic [DATA_W-1:0]              m_axis_tdata;
  logic                           m_axis_tvalid;
  logic                           m_axis_tlast;
  logic [DATA_W/8-1:0]            m_axis_tkeep;
  logic                           m_axis_tready;
  logic                           frame_done;
  logic                           tlast_err;

  axis_frame_pipe #(
    .DATA_W     (DATA_W),
    .FRAME_W    (FRAME_W),
    .FRAME_H    (FRAME_H),
    .PIPE_LAT   (PIPE_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .axi_Mclk      (axi_Mclk),
    .axi_reset     (axi_reset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .core_en       (core_en),
    .core_pix      (core_pix),
    .core_hs_cnt   (core_hs_cnt),
    .core_vs_cnt   (core_vs_cnt),
    .core_res      (core_res),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tready (m_axis_tready),
    .frame_done    (frame_done),
    .tlast_err     (tlast_err)
  );

  // ---------------- clock / reset ----------------
  initial axi_Mclk = 1'b0;
  always #5 axi_Mclk = ~axi_Mclk;

  int cyc = 0;
  always @(posedge axi_Mclk) cyc <= cyc + 1;

  // External core: result = pixel + 1, PIPE_LAT cycles later.
  logic [DATA_W-1:0] core_pipe [PIPE_LAT];
  always @(posedge axi_Mclk) begin
    core_pipe[0] <= core_pix + 1;
    for (int i = 1; i < PIPE_LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign core_res = core_pipe[PIPE_LAT-1];

  // ---------------- scoreboard ----------------
  logic [DATA_W:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int acc_cyc = -1;
  int first_out_cyc = -1;
  logic [1:0] beat_hs;
  logic [0:0] beat_vs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected entry per output transfer.
  always @(negedge axi_Mclk) begin
    logic [DATA_W:0] e;
    if (m_axis_tvalid && m_axis_tready) begin
      if (first_out_cyc < 0) first_out_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got data %0h expected none", m_axis_tdata);
      end else begin
        e = exp_q.pop_front();
        check("out_data", m_axis_tdata, e[DATA_W-1:0]);
        check("out_last", m_axis_tlast, e[DATA_W]);
        check("out_keep", m_axis_tkeep, 4'hf);
        check("frame_done", frame_done, e[DATA_W]);
      end
    end else if (frame_done) begin
      check("frame_done_idle", frame_done, 1'b0);
    end
    if (frame_done) fd_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge axi_Mclk);
    #1;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic tl,
                      input logic [DATA_W-1:0] exp_d, input logic exp_l);
    int k;
    s_axis_tdata  = d;
    s_axis_tlast  = tl;
    s_axis_tvalid = 1'b1;
    k = 0;
    while (!s_axis_tready && k < 200) begin
      step();
      k++;
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got ready 0 expected 1 for data %0h", d);
    end else begin
      if (acc_cyc < 0) acc_cyc = cyc;
      beat_hs = core_hs_cnt;
      beat_vs = core_vs_cnt;
      exp_q.push_back({exp_l, exp_d});
    end
    step();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      step();
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_reset();
    axi_reset = 1'b1;
    #1;
    check("rst_ready", s_axis_tready, 1'b0);
    check("rst_tlast_err", tlast_err, 1'b0);
    step();
    axi_reset = 1'b0;
    exp_q.delete();
    step();
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    axi_reset     = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;
    repeat (3) step();

    check("reset_s_tready", s_axis_tready, 1'b0);
    check("reset_m_tvalid", m_axis_tvalid, 1'b0);
    check("reset_m_tlast", m_axis_tlast, 1'b0);
    check("reset_m_tkeep", m_axis_tkeep, 4'h0);
    check("reset_frame_done", frame_done, 1'b0);
    check("reset_tlast_err", tlast_err, 1'b0);
    axi_reset = 1'b0;
    #1;
    check("ready_after_release", s_axis_tready, 1'b0);
    step();
    check("ready_rises", s_axis_tready, 1'b1);

    // Free run: 0..7 -> 1..8, last on the 8th.
    acc_cyc = -1;
    first_out_cyc = -1;
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(DATA_W'(i), i == 7, DATA_W'(i + 1), i == 7);
      if (i == 0) begin
        check("free_first_hs", beat_hs, 2'd0);
        check("free_first_vs", beat_vs, 1'b0);
      end
      if (i == 5) begin
        check("free_beat6_hs", beat_hs, 2'd1);
        check("free_beat6_vs", beat_vs, 1'b1);
      end
    end
    wait_drain();
    check("free_latency", first_out_cyc - acc_cyc, 4);
    check("free_frame_done_cnt", fd_cnt, 1);
    check("free_tlast_err", tlast_err, 1'b0);

    // Backpressure: 8 beats stall with output blocked.
    m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(DATA_W'(16 + i), i == 7, DATA_W'(17 + i), i == 7);
      if (i == 6) check("bp_ready_at_7", s_axis_tready, 1'b1);
    end
    check("bp_ready_low", s_axis_tready, 1'b0);
    repeat (38) step();
    check("bp_ready_held", s_axis_tready, 1'b0);
    check("bp_m_tvalid", m_axis_tvalid, 1'b1);
    m_axis_tready = 1'b1;
    wait_drain();
    step();
    check("bp_ready_back", s_axis_tready, 1'b1);

    // Early tlast on beat 5: error set, beat 6 resyncs to (0,0).
    for (int i = 0; i < 8; i++) begin
      send(DATA_W'(32 + i), i == 4, DATA_W'(33 + i), 1'b0);
      if (i == 3) check("early_err_before", tlast_err, 1'b0);
      if (i == 4) check("early_err_set", tlast_err, 1'b1);
      if (i == 5) begin
        check("early_resync_hs", beat_hs, 2'd0);
        check("early_resync_vs", beat_vs, 1'b0);
      end
    end
    wait_drain();
    check("early_err_sticky", tlast_err, 1'b1);
    pulse_reset();
    check("early_err_cleared", tlast_err, 1'b0);

    // Missing tlast on beat 8: error set, output still tagged last.
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(DATA_W'(48 + i), 1'b0, DATA_W'(49 + i), i == 7);
      if (i == 6) check("miss_err_before", tlast_err, 1'b0);
    end
    wait_drain();
    check("miss_err_set", tlast_err, 1'b1);
    check("miss_frame_done_cnt", fd_cnt, 1);
    pulse_reset();

    // Mid-frame reset after beat 3: everything in flight is discarded.
    for (int i = 0; i < 3; i++) send(DATA_W'(64 + i), 1'b0, DATA_W'(65 + i), 1'b0);
    axi_reset = 1'b1;
    #1;
    check("mid_rst_m_tvalid", m_axis_tvalid, 1'b0);
    step();
    axi_reset = 1'b0;
    exp_q.delete();
    check("mid_next_m_tvalid", m_axis_tvalid, 1'b0);
    check("mid_next_ready", s_axis_tready, 1'b0);
    step();
    check("mid_ready_rises", s_axis_tready, 1'b1);
    check("mid_no_stale", m_axis_tvalid, 1'b0);
    fd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      send(DATA_W'(80 + i), i == 7, DATA_W'(81 + i), i == 7);
      if (i == 0) begin
        check("mid_first_hs", beat_hs, 2'd0);
        check("mid_first_vs", beat_vs, 1'b0);
      end
    end
    wait_drain();
    repeat (10) step();
    check("mid_frame_done_cnt", fd_cnt, 1);
    check("mid_tlast_err", tlast_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
